apb_master_param: RTL and testbench
===================================

APB_MASTER_PARAM -- requirements
Module: apb_master_param

Interface
REQ-001 Parameter ADDR_W, default 32: APB address width.
REQ-002 Parameter DATA_W, default 32: APB data width.
REQ-003 Parameter NSLV, default 2: number of slaves (psel bits), 1..16.
REQ-004 Parameter TIMEOUT, default 16: max ACCESS wait cycles; 0 disables the timeout.
REQ-005 Clock and reset are decided: one clock; reset is asynchronous and active-low.
REQ-006 pclk  in  1  sole clock; all logic on rising edge.
REQ-007 prst  in  1  asynchronous active-low reset.
REQ-008 cmd_valid  in  1  command request.
REQ-009 cmd_ready  out  1  master can accept a command this cycle.
REQ-010 cmd_write  in  1  1 = write, 0 = read.
REQ-011 cmd_addr  in  ADDR_W  target address.
REQ-012 cmd_wdata  in  DATA_W  write data.
REQ-013 cmd_sel  in  max(1,clog2(NSLV))  slave index.
REQ-014 rsp_valid  out  1  one-cycle completion pulse.
REQ-015 rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
REQ-016 rsp_err  out  1  completion error flag, valid with rsp_valid.
REQ-017 psel  out  NSLV  one-hot APB select.
REQ-018 penable  out  1  APB enable.
REQ-019 pwrite  out  1  APB direction.
REQ-020 paddr  out  ADDR_W  APB address.
REQ-021 pwdata  out  DATA_W  APB write data.
REQ-022 prdata  in  DATA_W  read data, already muxed from the selected slave.
REQ-023 pready  in  1  slave ready.
REQ-024 pslverr  in  1  slave error, sampled with pready.

Function
REQ-025 The FSM SHALL have three states: IDLE, SETUP and ACCESS.
REQ-026 cmd_ready SHALL equal (state==IDLE) | (state==ACCESS & pready) | (state==ACCESS & timeout_hit).
REQ-027 A command is accepted on cmd_valid & cmd_ready; cmd_write, cmd_addr, cmd_wdata and cmd_sel SHALL be registered on acceptance.
REQ-028 Accepting a valid cmd_sel (< NSLV) SHALL enter SETUP next cycle with psel[cmd_sel]=1, penable=0, and pwrite/paddr/pwdata driving the registered values.
REQ-029 From SETUP the FSM SHALL always go to ACCESS next cycle, with penable=1 and psel, paddr, pwrite and pwdata unchanged.
REQ-030 In ACCESS with pready=1, the FSM SHALL complete: rsp_valid=1 next cycle, rsp_err=pslverr, rsp_rdata=prdata for reads (0 for writes or when pslverr=1).
REQ-031 On completion without a new command, the FSM SHALL go to IDLE with psel=0 and penable=0.
REQ-032 On completion with cmd_valid=1 (back-to-back), the FSM SHALL go directly to SETUP with penable=0 and the new psel/paddr/pwrite/pwdata; no IDLE cycle.
REQ-033 The wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with pready=0.
REQ-034 If TIMEOUT>0 and the counter reaches TIMEOUT with pready still 0, the FSM SHALL complete with rsp_err=1 and rsp_rdata=0, then follow REQ-031/032.
REQ-035 With TIMEOUT=0, ACCESS SHALL wait indefinitely for pready.
REQ-036 An accepted command with cmd_sel >= NSLV SHALL drive no APB activity (psel stays 0), SHALL give rsp_valid=1 with rsp_err=1 and rsp_rdata=0 next cycle, and SHALL leave the FSM in IDLE.
REQ-037 pwdata SHALL hold its last value during reads; pready and pslverr SHALL be ignored outside ACCESS.
REQ-038 rsp_valid SHALL be high for exactly one cycle per accepted command, with no backpressure.

Reset
REQ-039 While prst=0, all of the following SHALL be 0 asynchronously: state=IDLE, psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err and the wait counter.
REQ-040 Reset asserted mid-transfer SHALL abort the transfer with no rsp_valid; cmd_ready SHALL be 1 on the first clock after reset is released.

Verification
REQ-041 Write, sel=1, addr=0x10, data=0xA5A5A5A5, pready=1 in the first ACCESS cycle -> psel=2'b10 in SETUP, penable=1 in ACCESS, rsp_valid with err=0 three cycles after acceptance.
REQ-042 Read, sel=0, pready low for 3 ACCESS cycles, then prdata=0x12345678 -> penable high for 4 cycles, rsp_rdata=0x12345678, rsp_err=0.
REQ-043 Two back-to-back writes -> the second SETUP immediately follows the first ACCESS, penable drops for exactly one cycle, two rsp_valid pulses.
REQ-044 TIMEOUT=4, pready held at 0 -> completion after 4 wait cycles with rsp_err=1, psel=0; then pslverr=1 on a normal read gives rsp_err=1 and rsp_rdata=0.
REQ-045 cmd_sel=3 with NSLV=2 -> psel stays 0, rsp_valid=1 and rsp_err=1 one cycle after acceptance.
REQ-046 prst asserted during ACCESS -> all outputs 0 immediately, no rsp_valid, and a new command is accepted after reset is released.

Source files
------------

// File: rtl/apb_master_param.sv
// APB master that turns single-beat commands into SETUP/ACCESS transfers,
// with an optional ACCESS wait timeout and immediate error responses for bad slave indices.
module apb_master_param #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NSLV    = 2,
    parameter int TIMEOUT = 16,
    localparam int SEL_W  = (NSLV > 1) ? $clog2(NSLV) : 1
) (
    input  logic              pclk,
    input  logic              prst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [SEL_W-1:0]  cmd_sel,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [NSLV-1:0]   psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [SEL_W:0]   NSLV_L  = (SEL_W + 1)'(NSLV);
    localparam logic [NSLV-1:0]  SEL_ONE = NSLV'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [NSLV-1:0]   psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pend_q, pend_d;

    logic accept_s;
    logic sel_ok_s;
    logic timeout_hit_s;
    logic complete_s;
    logic load_s;

    assign timeout_hit_s = (TIMEOUT > 0) && (state_q == S_ACCESS) && !pready && (cnt_q == TO_LAST);
    assign complete_s    = (state_q == S_ACCESS) && (pready || timeout_hit_s);
    assign cmd_ready     = (state_q == S_IDLE) || complete_s;
    assign accept_s      = cmd_valid && cmd_ready;
    assign sel_ok_s      = ({1'b0, cmd_sel} < NSLV_L);

    // State register and all registered APB/response outputs.
    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            state_q     <= S_IDLE;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
        end
    end

    // Next-state and next-output logic for the IDLE/SETUP/ACCESS sequencer.
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        cnt_d       = cnt_q;
        pend_d      = 1'b0;
        load_s      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A bad-index error deferred from a completion cycle owns this response slot.
                if (pend_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    rsp_valid_d = 1'b0;
                end
                if (accept_s && sel_ok_s) begin
                    load_s = 1'b1;
                end else if (accept_s) begin
                    if (pend_q) begin
                        pend_d = 1'b1;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = S_ACCESS;
            end
            S_ACCESS: begin
                if (complete_s) begin
                    rsp_valid_d = 1'b1;
                    if (timeout_hit_s) begin
                        rsp_err_d = 1'b1;
                    end else begin
                        rsp_err_d   = pslverr;
                        rsp_rdata_d = (!pwrite_q && !pslverr) ? prdata : '0;
                    end
                    if (accept_s && sel_ok_s) begin
                        load_s = 1'b1;
                    end else begin
                        psel_d    = '0;
                        penable_d = 1'b0;
                        state_d   = S_IDLE;
                        pend_d    = accept_s;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                psel_d    = '0;
                penable_d = 1'b0;
            end
        endcase

        if (load_s) begin
            state_d   = S_SETUP;
            psel_d    = SEL_ONE << cmd_sel;
            penable_d = 1'b0;
            pwrite_d  = cmd_write;
            paddr_d   = cmd_addr;
            pwdata_d  = cmd_write ? cmd_wdata : pwdata_q;
        end else begin
            load_s = 1'b0;
        end
    end

    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_param.sv
// Scoreboard bench for apb_master_param: directed transfers against a simple APB slave model.
module tb_apb_master_param;

    logic        pclk = 1'b0;
    logic        prst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [1:0]  cmd_sel;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int n_checks = 0;
    int n_errors = 0;
    int rsp_cnt  = 0;
    logic [32:0] exp_q[$];

    // Slave model: ready after slv_wait ACCESS wait cycles; slv_wait < 0 never answers.
    int          slv_wait  = 0;
    logic        slv_err   = 1'b0;
    logic [31:0] slv_rdata = 32'h0;
    int          acc_cnt   = 0;

    apb_master_param #(
        .ADDR_W(32), .DATA_W(32), .NSLV(3), .TIMEOUT(4)
    ) dut (
        .pclk(pclk), .prst(prst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    assign pready  = penable && (slv_wait >= 0) && (acc_cnt == slv_wait);
    assign pslverr = slv_err;
    assign prdata  = slv_rdata;

    always @(posedge pclk) begin
        if (penable && !pready) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Response monitor: every rsp_valid pulse is matched against the oldest expectation.
    always @(negedge pclk) begin
        if (prst && rsp_valid) begin
            rsp_cnt <= rsp_cnt + 1;
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                check("rsp_err", {63'd0, rsp_err}, {63'd0, exp_q[0][32]});
                check("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, exp_q[0][31:0]});
                exp_q.delete(0);
            end
        end
    end

    task automatic send(input logic wr, input logic [1:0] sel, input logic [31:0] addr,
                        input logic [31:0] wd, input logic push, input logic e_err,
                        input logic [31:0] e_rd);
        int n = 0;
        @(negedge pclk);
        while (!cmd_ready && n < 50) begin
            @(negedge pclk);
            n++;
        end
        if (!cmd_ready) begin
            check("cmd_ready_wait", 64'd0, 64'd1);
            return;
        end
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_sel   = sel;
        cmd_addr  = addr;
        cmd_wdata = wd;
        if (push) exp_q.push_back({e_err, e_rd});
        @(posedge pclk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge pclk);
        @(negedge pclk);
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    initial begin
        int pen;
        int c0;
        prst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_addr = 32'h0; cmd_wdata = 32'h0; cmd_sel = 2'd0;
        #12;
        check("rst_psel", {61'd0, psel}, 64'd0);
        check("rst_penable", {63'd0, penable}, 64'd0);
        check("rst_paddr", {32'd0, paddr}, 64'd0);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        @(negedge pclk);
        prst = 1'b1;

        // Single write, zero wait.
        slv_wait = 0;
        send(1'b1, 2'd1, 32'h10, 32'hA5A5A5A5, 1'b1, 1'b0, 32'h0);
        check("wr_setup_psel", {61'd0, psel}, 64'h2);
        check("wr_setup_penable", {63'd0, penable}, 64'd0);
        check("wr_setup_paddr", {32'd0, paddr}, 64'h10);
        check("wr_setup_pwdata", {32'd0, pwdata}, 64'hA5A5A5A5);
        check("wr_setup_pwrite", {63'd0, pwrite}, 64'd1);
        tick();
        check("wr_access_penable", {63'd0, penable}, 64'd1);
        check("wr_access_psel", {61'd0, psel}, 64'h2);
        tick();
        check("wr_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        check("wr_idle_psel", {61'd0, psel}, 64'd0);
        check("wr_idle_penable", {63'd0, penable}, 64'd0);
        tick();
        check("wr_rsp_pulse", {63'd0, rsp_valid}, 64'd0);

        // Read with three wait cycles.
        slv_wait = 3; slv_rdata = 32'h12345678;
        send(1'b0, 2'd0, 32'h34, 32'hFFFF0000, 1'b1, 1'b0, 32'h12345678);
        check("rd_setup_psel", {61'd0, psel}, 64'h1);
        check("rd_pwdata_hold", {32'd0, pwdata}, 64'hA5A5A5A5);
        pen = 0;
        for (int i = 0; i < 20 && !rsp_valid; i++) begin
            tick();
            if (penable) pen++;
        end
        check("rd_penable_cycles", 64'(pen), 64'd4);
        check("rd_rdata", {32'd0, rsp_rdata}, 64'h12345678);
        drain();

        // Back-to-back writes: no IDLE between them.
        slv_wait = 0;
        c0 = rsp_cnt;
        send(1'b1, 2'd2, 32'h40, 32'h11111111, 1'b1, 1'b0, 32'h0);
        send(1'b1, 2'd1, 32'h44, 32'h22222222, 1'b1, 1'b0, 32'h0);
        check("b2b_setup_penable", {63'd0, penable}, 64'd0);
        check("b2b_setup_psel", {61'd0, psel}, 64'h2);
        check("b2b_setup_paddr", {32'd0, paddr}, 64'h44);
        check("b2b_first_rsp", {63'd0, rsp_valid}, 64'd1);
        tick();
        check("b2b_access_penable", {63'd0, penable}, 64'd1);
        drain();
        check("b2b_rsp_count", 64'(rsp_cnt - c0), 64'd2);

        // Timeout, then slave error on a read.
        slv_wait = -1;
        send(1'b1, 2'd0, 32'h20, 32'h33333333, 1'b1, 1'b1, 32'h0);
        pen = 0;
        for (int i = 0; i < 20 && !rsp_valid; i++) begin
            tick();
            if (penable) pen++;
        end
        check("to_penable_cycles", 64'(pen), 64'd4);
        check("to_psel", {61'd0, psel}, 64'd0);
        drain();
        slv_wait = 0; slv_err = 1'b1; slv_rdata = 32'hDEADBEEF;
        send(1'b0, 2'd1, 32'h24, 32'h0, 1'b1, 1'b1, 32'h0);
        drain();
        slv_err = 1'b0;

        // Out-of-range slave index.
        send(1'b0, 2'd3, 32'h50, 32'h0, 1'b1, 1'b1, 32'h0);
        check("bad_psel", {61'd0, psel}, 64'd0);
        check("bad_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        check("bad_rsp_err", {63'd0, rsp_err}, 64'd1);
        check("bad_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        tick();
        check("bad_rsp_pulse", {63'd0, rsp_valid}, 64'd0);

        // Bad index accepted on the completion cycle of a good transfer.
        c0 = rsp_cnt;
        send(1'b1, 2'd2, 32'h60, 32'h44444444, 1'b1, 1'b0, 32'h0);
        send(1'b1, 2'd3, 32'h64, 32'h55555555, 1'b1, 1'b1, 32'h0);
        drain();
        check("coll_rsp_count", 64'(rsp_cnt - c0), 64'd2);

        // Reset during ACCESS.
        slv_wait = -1;
        send(1'b0, 2'd1, 32'h80, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        check("rst_mid_in_access", {63'd0, penable}, 64'd1);
        @(negedge pclk);
        prst = 1'b0;
        #1;
        check("rst_mid_psel", {61'd0, psel}, 64'd0);
        check("rst_mid_penable", {63'd0, penable}, 64'd0);
        check("rst_mid_paddr", {32'd0, paddr}, 64'd0);
        check("rst_mid_pwdata", {32'd0, pwdata}, 64'd0);
        check("rst_mid_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        tick();
        tick();
        @(negedge pclk);
        prst = 1'b1;
        slv_wait = 0;
        tick();
        check("rst_rel_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        send(1'b1, 2'd0, 32'h90, 32'h66666666, 1'b1, 1'b0, 32'h0);
        check("rst_rel_psel", {61'd0, psel}, 64'h1);
        drain();
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
